// File: rtl/drv_burst_sched.sv
// Drive-clock burst sequencer: DRV2 square wave, H cycles per half-period, N high pulses; optional dead-time via DRV_DEADTIME_EN.
// Latency: first DRV2 rise H edges after start; done one cycle after the last fall.
// Backpressure: SYN1OUT freezes counting and toggling (stall + one resume cycle); abort returns to idle at once.
module drv_burst_sched #(
`ifdef DRV_DEADTIME_EN
    parameter int DT_CYC       = 4,
`endif
    parameter int CNT_W        = 16,
    parameter int NUM_W        = 16,
    parameter int DEFAULT_HALF = 51
) (
    input  logic             CLKIN,
    input  logic             Reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] half_period,
    input  logic [NUM_W-1:0] pulse_count,
    input  logic             SYN1OUT,
    output logic             DRV2,
`ifdef DRV_DEADTIME_EN
    output logic             DRV2_N,
`endif
    output logic             busy,
    output logic             held,
    output logic             done,
    output logic [NUM_W-1:0] pulses_left
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [NUM_W-1:0] left_q, left_d;
    logic             drv_q, drv_d;
    logic             toggle;
    logic             run_entry;

    always_ff @(posedge CLKIN or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            left_q  <= '0;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            left_q  <= left_d;
            drv_q   <= drv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        left_d    = left_q;
        drv_d     = drv_q;
        toggle    = 1'b0;
        run_entry = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    half_d = (half_period == '0) ? CNT_W'(DEFAULT_HALF) : half_period;
                    left_d = pulse_count;
                    cnt_d  = '0;
                    drv_d  = 1'b0;
                    if (pulse_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RUN;
                        run_entry = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    left_d  = '0;
                    drv_d   = 1'b0;
                end else if (SYN1OUT) begin
                    state_d = HOLD;
                end else if (cnt_q == half_q - CNT_W'(1)) begin
                    cnt_d  = '0;
                    drv_d  = ~drv_q;
                    toggle = 1'b1;
                    // a pulse is only spent on its falling edge; the last one ends the burst
                    if (drv_q) begin
                        left_d = left_q - NUM_W'(1);
                        if (left_q == NUM_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    left_d  = '0;
                    drv_d   = 1'b0;
                end else if (!SYN1OUT) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                left_d  = '0;
                drv_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DRV_DEADTIME_EN
    localparam int DT_W = (DT_CYC > 0) ? $clog2(DT_CYC + 1) : 1;

    logic [DT_W-1:0] dt_q, dt_d;

    always_ff @(posedge CLKIN or negedge Reset) begin
        if (!Reset) begin
            dt_q <= '0;
        end else begin
            dt_q <= dt_d;
        end
    end

    // reload wins over the countdown, so H <= DT_CYC keeps both outputs low all burst
    always_comb begin
        dt_d = dt_q;
        if (run_entry || toggle) begin
            dt_d = DT_W'(DT_CYC);
        end else if (state_q == RUN && dt_q != '0) begin
            dt_d = dt_q - DT_W'(1);
        end
    end

    assign DRV2   = drv_q & (dt_q == '0);
    assign DRV2_N = ~drv_q & (dt_q == '0) & ((state_q == RUN) || (state_q == HOLD));
`else
    assign DRV2 = drv_q;
`endif

    assign busy        = (state_q != IDLE);
    assign held        = (state_q == HOLD);
    assign done        = (state_q == DONE);
    assign pulses_left = left_q;

endmodule

// File: doc/drv_burst_sched.md
Name: drv_burst_sched

Overview:
- Sequencer for the drive-clock generator: produces DRV2 as a gated square-wave burst with a programmable half-period and pulse count.
- Burst starts on command and stalls while the sync line SYN1OUT is high.
- Reports busy/done status to the upstream control logic.
- Replaces the free-running fixed-ratio divider with a configurable, countable drive burst.

Parameters:
- CNT_W, 16, width of the half-period counter and the half_period input.
- NUM_W, 16, width of the pulse counter, the pulse_count input and the pulses_left output.
- DEFAULT_HALF, 51, half-period used when half_period==0 is latched.
- DT_CYC, 4, dead-time in CLKIN cycles; used only with DRV_DEADTIME_EN.

Ports:
- CLKIN  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle burst request; honoured only in IDLE.
- abort  in  1  terminates any burst immediately; has priority over start.
- half_period  in  CNT_W  CLKIN cycles per DRV2 half-period; latched at start.
- pulse_count  in  NUM_W  number of DRV2 high pulses per burst; latched at start.
- SYN1OUT  in  1  stall: while 1, counting and toggling freeze.
- DRV2  out  1  drive clock output.
- busy  out  1  1 whenever state != IDLE.
- held  out  1  1 while in HOLD.
- done  out  1  one-cycle pulse at normal burst completion.
- pulses_left  out  NUM_W  remaining high pulses; 0 in IDLE.

Behaviour:
- Reset low (asynchronous): state=IDLE; DRV2=0, busy=0, held=0, done=0, pulses_left=0; counter=0; latched H=0.
- States: IDLE=0, RUN=1, HOLD=2, DONE=3.
- IDLE:
  - start=1 and abort=0 at edge k: latch H=half_period, or DEFAULT_HALF if half_period==0.
  - Same edge: latch pulses_left=pulse_count; counter=0; DRV2=0.
  - pulse_count==0: go to DONE (no DRV2 activity). Otherwise go to RUN.
- RUN, each edge:
  - abort=1: go to IDLE.
  - Else SYN1OUT=1: go to HOLD; counter and DRV2 unchanged.
  - Else if counter==H-1: counter=0; DRV2 toggles.
  - Else counter+1.
- Falling toggle (DRV2 1->0): pulses_left decrements. If the result is 0, go to DONE at that same edge.
- HOLD:
  - abort=1: go to IDLE.
  - SYN1OUT=0: return to RUN; no count on that edge.
  - Each stall cycle delays the burst by exactly one cycle, plus one resume cycle.
- DONE: done=1 and busy=1 for exactly one cycle; DRV2=0; then IDLE.
- Timing without stall (start at edge k):
  - First DRV2 rise at edge k+H.
  - Period is 2H; duty is exactly 50%.
  - Last fall at edge k+2·N·H; done high for the following cycle; busy falls at edge k+2·N·H+1.
- Abort in any non-IDLE state: next edge forces IDLE, DRV2=0, pulses_left=0, no done pulse. A start in the same cycle is ignored.
- start while busy: ignored; latched H and N unchanged.
- half_period/pulse_count changes after start have no effect on the current burst.
- Counter is CNT_W bits. H=1 gives toggling every cycle (period 2). H=2^CNT_W-1 is legal.
- done and abort never assert done in the same cycle.

Optional Feature:
- Macro: DRV_DEADTIME_EN.
- Defined:
  - Adds output DRV2_N (1 bit, reset 0), the complementary drive.
  - Internal raw toggle drv_raw follows the rules above.
  - dt_cnt loads DT_CYC on every drv_raw toggle and on entry to RUN, then counts down to 0.
  - DRV2 = drv_raw & (dt_cnt==0).
  - DRV2_N = ~drv_raw & (dt_cnt==0) & (state is RUN or HOLD).
  - dt_cnt freezes in HOLD.
  - If H <= DT_CYC, both outputs stay 0 for the whole burst; burst timing and done are unchanged.
- Undefined: no DRV2_N port; DRV2 = drv_raw.

Test Plan:
- Basic burst: half_period=3, pulse_count=2, SYN1OUT=0, start at edge k → DRV2 rises at k+3, falls k+6, rises k+9, falls k+12; done=1 during cycle k+12..k+13; busy=0 from k+13.
- Default half and zero count:
  - half_period=0, pulse_count=1 → DRV2 high for 51 cycles after 51 low; done once.
  - pulse_count=0 → done one cycle after start; DRV2 never rises.
- Stall: H=4, N=1, SYN1OUT=1 for 5 cycles mid-low-phase → held=1 for 5 cycles; rise delayed 6 cycles vs. unstalled; high phase still 4 cycles.
- Abort: H=10, N=5, abort during third high phase → next edge DRV2=0, busy=0, pulses_left=0, done never pulses. start+abort together in IDLE → stays IDLE.
- Ignored start and async reset: start pulse during RUN with different inputs → period unchanged. Reset low mid-burst (not clock-aligned) → all outputs 0 immediately.
- DRV_DEADTIME_EN, DT_CYC=2, H=6, N=2:
  - Every DRV2 edge is separated from the opposite DRV2_N edge by 2 cycles with both outputs low; DRV2 and DRV2_N are never 1 together.
  - H=2 → both outputs stay 0 and done still arrives on time.
